// File: rtl/wf_gather_queue_pkg.sv
// Shared constants and helpers for the wavefront-gather queue and its RAM.
package wf_gather_queue_pkg;

  localparam int DEFAULT_WIDTH  = 39;
  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_AF_LVL = 6;

  // Pointer width for a power-of-two depth; count needs one more bit to reach DEPTH.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wf_gather_queue_if.sv
// Enqueue/dequeue handshake, flush and status bundle for wf_gather_queue.
interface wf_gather_queue_if #(
  parameter int WIDTH = 39,
  parameter int AW    = 3
);
  logic             io_flush;
  logic             io_enq_valid;
  logic             io_enq_ready;
  logic [WIDTH-1:0] io_enq_bits;
  logic             io_deq_valid;
  logic             io_deq_ready;
  logic [WIDTH-1:0] io_deq_bits;
  logic [AW:0]      io_count;
  logic             io_almost_full;

  modport master (
    output io_flush, io_enq_valid, io_enq_bits, io_deq_ready,
    input  io_enq_ready, io_deq_valid, io_deq_bits, io_count, io_almost_full
  );

  modport slave (
    input  io_flush, io_enq_valid, io_enq_bits, io_deq_ready,
    output io_enq_ready, io_deq_valid, io_deq_bits, io_count, io_almost_full
  );
endinterface

// File: rtl/wf_gather_ram_1w1r.sv
// One-write one-read RAM with a registered (synchronous) read port.
module wf_gather_ram_1w1r #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [WIDTH-1:0] W0_data,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto RAM macros; readers must never trust its power-up contents.
  always_ff @(posedge clock) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) rdata_q <= mem[R0_addr];
  end

  assign R0_data = rdata_q;
endmodule

// File: rtl/wf_gather_queue.sv
// Show-ahead ready/valid FIFO on a sync-read RAM, with flush, occupancy and write-to-read bypass.
module wf_gather_queue
  import wf_gather_queue_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AF_LVL = DEFAULT_AF_LVL
) (
  input logic              clock,
  input logic              reset,
  wf_gather_queue_if.slave io
);
  localparam int          AW       = ptr_w(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LVL);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, raddr;
  logic [AW:0]      count_q, count_d;
  logic             byp_sel_q, byp_sel_d;
  logic [WIDTH-1:0] byp_data_q, byp_data_d, ram_q;
  logic             enq_ready, deq_valid, enq_fire, deq_fire;

  // NOTE: every signal gets a default at the top of the block so no path can leave it unassigned and infer a latch.
  always_comb begin
    enq_ready  = !reset && !io.io_flush && (count_q != FULL_CNT);
    deq_valid  = !reset && !io.io_flush && (count_q != '0);
    enq_fire   = io.io_enq_valid && enq_ready;
    deq_fire   = deq_valid && io.io_deq_ready;
    raddr      = deq_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    byp_sel_d  = enq_fire && (wr_ptr_q == raddr);
    byp_data_d = enq_fire ? io.io_enq_bits : byp_data_q;

    if (io.io_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq_fire) rd_ptr_d = raddr;
      if (enq_fire && !deq_fire) count_d = count_q + (AW+1)'(1);
      if (!enq_fire && deq_fire) count_d = count_q - (AW+1)'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      byp_sel_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      byp_sel_q <= byp_sel_d;
    end
  end

  // Payload-only register; byp_sel_q alone decides whether it is looked at.
  always_ff @(posedge clock) begin
    byp_data_q <= byp_data_d;
  end

  wf_gather_ram_1w1r #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock   (clock),
    .W0_addr (wr_ptr_q),
    .W0_en   (enq_fire),
    .W0_data (io.io_enq_bits),
    .R0_addr (raddr),
    .R0_en   (1'b1),
    .R0_data (ram_q)
  );

  assign io.io_enq_ready   = enq_ready;
  assign io.io_deq_valid   = deq_valid;
  assign io.io_deq_bits    = byp_sel_q ? byp_data_q : ram_q;
  assign io.io_count       = reset ? '0 : count_q;
  assign io.io_almost_full = !reset && (count_q >= AF_CNT);

  a_no_enq_full:  assert property (@(posedge clock) disable iff (reset) !(enq_fire && count_q == FULL_CNT));
  a_no_deq_empty: assert property (@(posedge clock) disable iff (reset) !(deq_fire && count_q == '0));
  a_count_range:  assert property (@(posedge clock) disable iff (reset) count_q <= FULL_CNT);
endmodule

// File: tb/tb_wf_gather_queue.sv
// Self-checking bench for wf_gather_queue: directed vector table, corner sequences, random vs queue model.
module tb_wf_gather_queue;
  localparam int W = 39;
  localparam int D = 8;
  localparam int AF = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wf_gather_queue_if #(.WIDTH(W), .AW(3)) io ();

  wf_gather_queue #(.WIDTH(W), .DEPTH(D), .AF_LVL(AF)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] model_q[$];

  typedef struct {
    logic rst, flush, ev;
    logic [W-1:0] eb;
    logic dr;
    logic er, dv;
    logic [W-1:0] bits;
    logic [3:0] cnt;
    logic af;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against the queue model, then apply the model update at posedge.
  task automatic cycle(input logic r, input logic f, input logic ev, input logic [W-1:0] eb, input logic dr,
                       output logic er, output logic dv, output logic [W-1:0] bits,
                       output logic [3:0] cnt, output logic af);
    logic m_er, m_dv, efire, dfire;
    int sz;
    @(negedge clock);
    reset = r; io.io_flush = f; io.io_enq_valid = ev; io.io_enq_bits = eb; io.io_deq_ready = dr;
    #1;
    er = io.io_enq_ready; dv = io.io_deq_valid; bits = io.io_deq_bits; cnt = io.io_count; af = io.io_almost_full;
    sz   = model_q.size();
    m_er = !r && !f && (sz < D);
    m_dv = !r && !f && (sz > 0);
    check("enq_ready", er, m_er);
    check("deq_valid", dv, m_dv);
    check("count", cnt, r ? 0 : sz);
    check("almost_full", af, !r && (sz >= AF));
    if (m_dv) check("deq_bits", bits, model_q[0]);
    efire = ev && m_er;
    dfire = dr && m_dv;
    @(posedge clock);
    if (r || f) model_q.delete();
    else begin
      if (dfire) void'(model_q.pop_front());
      if (efire) model_q.push_back(eb);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic flush, input logic ev, input logic [W-1:0] eb,
                              input logic dr, input logic er, input logic dv, input logic [W-1:0] bits,
                              input logic [3:0] cnt, input logic af);
    vec_t v;
    v.rst = rst; v.flush = flush; v.ev = ev; v.eb = eb; v.dr = dr;
    v.er = er; v.dv = dv; v.bits = bits; v.cnt = cnt; v.af = af;
    return v;
  endfunction

  initial begin
    logic er, dv, af;
    logic [W-1:0] bits;
    logic [3:0] cnt;

    io.io_flush = 0; io.io_enq_valid = 0; io.io_enq_bits = '0; io.io_deq_ready = 0;

    // Reset, idle, single enq with immediate show-ahead, fill to full, full+deq, refill.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 'x, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0, 1, 0, 'x,   0, 0));
    vecs.push_back(mk(0, 0, 1, 'h11, 1, 1, 0, 'x,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0,    1, 1, 1, 'h11, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0, 1, 0, 'x,   0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 1, W'('h20 + i), 0, 1, i != 0, (i != 0) ? W'('h20) : 'x, 4'(i), i >= AF));
    vecs.push_back(mk(0, 0, 1, 'h99, 0, 0, 1, 'h20, 8, 1));
    vecs.push_back(mk(0, 0, 1, 'h99, 1, 0, 1, 'h20, 8, 1));
    vecs.push_back(mk(0, 0, 1, 'h99, 0, 1, 1, 'h21, 7, 1));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 1, 'h21, 8, 1));

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].flush, vecs[i].ev, vecs[i].eb, vecs[i].dr, er, dv, bits, cnt, af);
      check($sformatf("vec%0d_enq_ready", i), er, vecs[i].er);
      check($sformatf("vec%0d_deq_valid", i), dv, vecs[i].dv);
      check($sformatf("vec%0d_count", i), cnt, vecs[i].cnt);
      check($sformatf("vec%0d_almost_full", i), af, vecs[i].af);
      if (vecs[i].dv) check($sformatf("vec%0d_deq_bits", i), bits, vecs[i].bits);
    end

    // Streaming across several pointer wraps: one entry held, enq+deq every cycle.
    cycle(1, 0, 0, 0, 0, er, dv, bits, cnt, af);
    cycle(0, 0, 1, 'h300, 0, er, dv, bits, cnt, af);
    for (int i = 1; i <= 40; i++) begin
      cycle(0, 0, 1, W'('h300 + i), 1, er, dv, bits, cnt, af);
      check("stream_valid", dv, 1'b1);
      check("stream_count", cnt, 4'd1);
      check("stream_bits", bits, W'('h300 + i - 1));
    end
    // Streaming with three entries held, so reads come from the RAM rather than the bypass.
    cycle(0, 0, 1, 'h400, 0, er, dv, bits, cnt, af);
    cycle(0, 0, 1, 'h401, 0, er, dv, bits, cnt, af);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 1, W'('h500 + i), 1, er, dv, bits, cnt, af);
      check("stream3_count", cnt, 4'd3);
    end

    // Flush with a concurrent enq: both dropped, then a fresh entry comes out intact.
    cycle(1, 0, 0, 0, 0, er, dv, bits, cnt, af);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, W'('hA0 + i), 0, er, dv, bits, cnt, af);
    cycle(0, 1, 1, 'hEE, 0, er, dv, bits, cnt, af);
    check("flush_enq_ready", er, 1'b0);
    check("flush_deq_valid", dv, 1'b0);
    check("flush_count_hold", cnt, 4'd5);
    cycle(0, 0, 0, 0, 1, er, dv, bits, cnt, af);
    check("post_flush_count", cnt, 4'd0);
    check("post_flush_valid", dv, 1'b0);
    cycle(0, 0, 1, 'hAB, 0, er, dv, bits, cnt, af);
    cycle(0, 0, 0, 0, 1, er, dv, bits, cnt, af);
    check("after_flush_valid", dv, 1'b1);
    check("after_flush_bits", bits, W'('hAB));
    check("after_flush_count", cnt, 4'd1);
    cycle(0, 0, 0, 0, 0, er, dv, bits, cnt, af);
    check("after_flush_empty", cnt, 4'd0);

    // Random traffic with occasional flush and reset, checked against the queue model.
    for (int i = 0; i < 3000; i++) begin
      logic r, f, ev, dr;
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 39) == 0);
      ev = ($urandom_range(0, 99) < 60);
      dr = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 40 : 75));
      cycle(r, f, ev, {$urandom(), $urandom()} & {W{1'b1}}, dr, er, dv, bits, cnt, af);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
